// File: rtl/bg_sar_ctrl.sv
// bg_sar_ctrl: successive-approximation controller for the buffered bandgap.
// It drives a WIDTH-bit trial code to an external R-2R DAC and reads back an
// asynchronous comparator through a 2-flop synchroniser. Each bit gets
// SETTLE_CYCLES settle cycles and then one decide cycle. The finished code is
// published on result, together with a one-cycle valid strobe.
// Optional macro BG_SAR_AVG_EN: when defined, four back-to-back conversions
// are summed and the truncated mean is published on the fourth DONE.
module bg_sar_ctrl #(
  parameter int WIDTH         = 8,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             start,
  input  logic             cont,
  input  logic             comp_in,
  output logic [WIDTH-1:0] dac_code,
  output logic [WIDTH-1:0] result,
  output logic             valid,
  output logic             busy
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]    IDX_TOP   = IW'(WIDTH-1);
  localparam logic [3:0]       CNT_TOP   = 4'(SETTLE_CYCLES-1);
  localparam logic [WIDTH-1:0] MSB_TRIAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_DECIDE, S_DONE} state_t;

  state_t           state, nxt;
  logic [IW-1:0]    idx;
  logic [3:0]       cnt;
  logic             comp_q1, comp_s;
  logic [WIDTH-1:0] decided;     // current code with this bit's decision applied
  logic [WIDTH-1:0] trial_next;  // decided code plus the next lower trial bit
  logic             restart;     // DONE goes straight back to SETTLE
  logic             last_conv;   // this conversion publishes a result
  logic             load_msb, reload, finish, clear_dac;

`ifdef BG_SAR_AVG_EN
  logic [1:0]       conv_cnt;
  logic [WIDTH+1:0] acc, acc_sum;

  // Intermediate conversions of an averaging group always chain; only the
  // fourth one publishes.
  always_comb begin
    restart   = cont || (conv_cnt != 2'd0);
    last_conv = (conv_cnt == 2'd3);
    acc_sum   = acc + {2'b00, decided};
  end
`else
  // A single conversion publishes; cont alone decides whether to chain.
  always_comb begin
    restart   = cont;
    last_conv = 1'b1;
  end
`endif

  // Two-flop synchroniser on the asynchronous comparator output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      comp_q1 <= 1'b0;
      comp_s  <= 1'b0;
    end else begin
      comp_q1 <= comp_in;
      comp_s  <= comp_q1;
    end
  end

  // Trial-code arithmetic: apply the decision and set the next trial bit.
  always_comb begin
    decided = dac_code;
    if (!comp_s) decided[idx] = 1'b0;
    trial_next = decided;
    if (idx != '0) trial_next[idx - IW'(1)] = 1'b1;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= nxt;
  end

  // Next-state logic; ena low aborts from any state.
  always_comb begin
    nxt = state;
    if (!ena) begin
      nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) nxt = S_SETTLE;
        S_SETTLE: if (cnt == 4'd0) nxt = S_DECIDE;
        S_DECIDE: nxt = (idx == '0) ? S_DONE : S_SETTLE;
        S_DONE:   nxt = restart ? S_SETTLE : S_IDLE;
        default:  nxt = S_IDLE;
      endcase
    end
  end

  // Output decode: busy plus the datapath control strobes.
  always_comb begin
    busy      = (state != S_IDLE);
    clear_dac = !ena || (nxt == S_IDLE);
    load_msb  = (nxt == S_SETTLE) && ((state == S_IDLE) || (state == S_DONE));
    reload    = (state == S_DECIDE) && (idx != '0);
    finish    = (state == S_DECIDE) && (idx == '0);
  end

  // Datapath: trial code, bit index, settle counter and the published result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dac_code <= '0;
      result   <= '0;
      valid    <= 1'b0;
      idx      <= IDX_TOP;
      cnt      <= 4'd0;
`ifdef BG_SAR_AVG_EN
      acc      <= '0;
      conv_cnt <= 2'd0;
`endif
    end else begin
      valid <= 1'b0;
      if (clear_dac) begin
        dac_code <= '0;
        idx      <= IDX_TOP;
        cnt      <= 4'd0;
`ifdef BG_SAR_AVG_EN
        if (!ena) begin
          acc      <= '0;
          conv_cnt <= 2'd0;
        end
`endif
      end else if (load_msb) begin
        dac_code <= MSB_TRIAL;
        idx      <= IDX_TOP;
        cnt      <= CNT_TOP;
      end else if (reload) begin
        dac_code <= trial_next;
        idx      <= idx - IW'(1);
        cnt      <= CNT_TOP;
      end else if (finish) begin
        // Final decision lands in the register that is visible in DONE.
        dac_code <= decided;
`ifdef BG_SAR_AVG_EN
        conv_cnt <= conv_cnt + 2'd1;
        if (last_conv) begin
          result <= acc_sum[WIDTH+1:2];
          valid  <= 1'b1;
          acc    <= '0;
        end else begin
          acc    <= acc_sum;
        end
`else
        if (last_conv) begin
          result <= decided;
          valid  <= 1'b1;
        end
`endif
      end else if ((state == S_SETTLE) && (cnt != 4'd0)) begin
        cnt <= cnt - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_bg_sar_ctrl.sv
// Scoreboard bench for bg_sar_ctrl. A threshold comparator model drives
// comp_in from dac_code. Expected results come from the SAR contract: the
// largest code that the comparator accepts, averaged over four conversions
// when BG_SAR_AVG_EN is defined.
module tb_bg_sar_ctrl;
  localparam int W    = 8;
  localparam int S    = 4;
  localparam int CONV = W * (S + 1) + 1;
`ifdef BG_SAR_AVG_EN
  localparam int LAT  = 4 * CONV;
`else
  localparam int LAT  = CONV;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, ena = 1'b0, start = 1'b0, cont = 1'b0;
  logic         comp_in, valid, busy;
  logic [W-1:0] dac_code, result;
  int           thr = 0;
  int           cyc = 0;
  int           tests = 0, fails = 0;

  typedef struct { int val; int at; } exp_t;
  exp_t sb[$];

  bg_sar_ctrl #(.WIDTH(W), .SETTLE_CYCLES(S)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cont(cont),
    .comp_in(comp_in), .dac_code(dac_code), .result(result),
    .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Comparator: reference at threshold thr; thr=-1 means always 0.
  always_comb comp_in = (int'(dac_code) <= thr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Result the SAR must settle on for a threshold comparator.
  function automatic int sar_expect(input int t);
    if (t < 0) return 0;
    if (t > (1 << W) - 1) return (1 << W) - 1;
    return t;
  endfunction

  // Monitor: every valid pops one expectation.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("result", 32'(result), 32'(e.val));
        chk("valid_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  task automatic wait_until(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Pulse start for one edge; e is the accept-edge cycle (cycle 0).
  task automatic pulse_start(output int e);
    e = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One full (possibly averaged) conversion at a fixed threshold.
  task automatic run_one(input int t, input bit restart_mid);
    int e;
    thr = t;
    pulse_start(e);
    sb.push_back('{sar_expect(t), e + LAT});
    chk("busy_cycle1", 32'(busy), 32'd1);
    if (restart_mid) begin
      wait_until(e + 10);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    wait_until(e + LAT);
    chk("busy_in_done", 32'(busy), 32'd1);
    @(negedge clk);
    chk("busy_after", 32'(busy), 32'd0);
    chk("dac_after", 32'(dac_code), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int e;
    repeat (2) @(negedge clk);
    chk("rst_dac", 32'(dac_code), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    rst_n = 1'b1;
    ena   = 1'b1;
    repeat (2) @(negedge clk);

    run_one(8'h9C, 1'b0);
    run_one(255, 1'b0);   // comparator always 1
    run_one(-1, 1'b0);    // comparator always 0
    run_one(8'h9C, 1'b1); // start re-pulsed mid-conversion is ignored

    // Reset mid-conversion: outputs clear at once, no valid.
    thr = 8'h55;
    pulse_start(e);
    wait_until(e + 20);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dac", 32'(dac_code), 32'd0);
    chk("arst_result", 32'(result), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_valid", 32'(valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (LAT + 4) @(negedge clk);

    // ena abort: IDLE next cycle, result retained.
    run_one(8'h9C, 1'b0);
    thr = 8'h33;
    pulse_start(e);
    wait_until(e + 20);
    ena = 1'b0;
    @(negedge clk);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_dac", 32'(dac_code), 32'd0);
    chk("abort_result", 32'(result), 32'h9C);
    ena = 1'b1;
    repeat (LAT + 4) @(negedge clk);

    // Continuous mode: two results back to back, cont dropped mid-second.
    cont = 1'b1;
    thr  = 8'h9C;
    pulse_start(e);
    sb.push_back('{8'h9C, e + LAT});
    sb.push_back('{8'h21, e + 2 * LAT});
    wait_until(e + LAT);
    thr = 8'h21;
    wait_until(e + LAT + LAT / 2);
    cont = 1'b0;
    wait_until(e + 2 * LAT + 1);
    chk("cont_idle_busy", 32'(busy), 32'd0);
    repeat (4) @(negedge clk);

`ifdef BG_SAR_AVG_EN
    // Averaging group with a different threshold per conversion.
    begin
      int ths[4] = '{8'h10, 8'h11, 8'h12, 8'h14};
      int sum = 0;
      foreach (ths[k]) sum += sar_expect(ths[k]);
      thr = ths[0];
      pulse_start(e);
      sb.push_back('{sum / 4, e + LAT});
      for (int k = 1; k < 4; k++) begin
        wait_until(e + k * CONV);
        thr = ths[k];
      end
      wait_until(e + LAT + 4);
    end
`endif

    // Randomised thresholds across the full code range and just outside it.
    for (int n = 0; n < 6; n++) run_one(int'($urandom_range(0, 257)) - 1, 1'b0);

    repeat (5) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
